// File: rtl/bp_be_pkg.sv
// Shared types for the backend next-PC director.
package bp_be_pkg;

   // Director FSM states.
   typedef enum logic [1:0] {
      e_run      = 2'd0,
      e_redirect = 2'd1,
      e_drain    = 2'd2
   } bp_be_npc_dir_state_e;

   localparam int unsigned bp_vaddr_width_gp = 39;

   // Branch packet as produced by the control pipe. The director keeps its
   // ports flattened, so the fields map one-to-one onto br_*_i.
   typedef struct packed {
      logic                         v;
      logic                         branch;
      logic                         btaken;
      logic [bp_vaddr_width_gp-1:0] npc;
   } bp_be_branch_pkt_s;

endpackage

// File: rtl/bp_be_perf_cnt.sv
// Enable-incremented wrapping performance counter.
module bp_be_perf_cnt #(
   parameter int unsigned width_p = 32
) (
   input  logic               clk_i,
   input  logic               reset_n_i,
   input  logic               en_i,
   output logic [width_p-1:0] cnt_o
);

   logic [width_p-1:0] cnt_d, cnt_q;

   // Next count: increment when enabled, wrapping naturally at 2^width_p.
   always_comb begin
      cnt_d = cnt_q;
      if (en_i) cnt_d = cnt_q + width_p'(1);
   end

   // Counter register, cleared asynchronously.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) cnt_q <= '0;
      else            cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/bp_be_npc_director.sv
// Tracks the architecturally expected next PC, flushes the BE and redirects
// the FE on a mismatch, then drains wrong-path issues until the FE resyncs.
//
// Handshake: the FE command transfers on a cycle where fe_cmd_v_o and
// fe_cmd_ready_i are both high. fe_cmd_v_o never depends on fe_cmd_ready_i,
// and the command payload holds steady while fe_cmd_v_o is high and
// fe_cmd_ready_i is low. Ready may be high before valid.
module bp_be_npc_director
   import bp_be_pkg::*;
#(
   parameter int unsigned               vaddr_width_p = 39,
   parameter logic [vaddr_width_p-1:0]  reset_pc_p    = vaddr_width_p'(39'h0080000000),
   parameter int unsigned               cnt_width_p   = 32
) (
   input  logic                     clk_i,
   input  logic                     reset_n_i,

   input  logic                     br_v_i,
   input  logic                     br_branch_i,
   input  logic                     br_btaken_i,
   input  logic [vaddr_width_p-1:0] br_npc_i,

   input  logic                     issue_v_i,
   input  logic [vaddr_width_p-1:0] issue_pc_i,

   output logic                     flush_o,
   output logic                     stall_o,

   output logic                     fe_cmd_v_o,
   input  logic                     fe_cmd_ready_i,
   output logic [vaddr_width_p-1:0] fe_cmd_npc_o,
   output logic                     fe_cmd_branch_o,
   output logic                     fe_cmd_taken_o,

   output logic [cnt_width_p-1:0]   branch_cnt_o,
   output logic [cnt_width_p-1:0]   mispredict_cnt_o,

   output bp_be_npc_dir_state_e     dbg_state_o
);

   bp_be_npc_dir_state_e     state_d, state_q;
   logic [vaddr_width_p-1:0] npc_d, npc_q;
   logic                     npc_v_d, npc_v_q;
   logic                     branch_d, branch_q;
   logic                     taken_d, taken_q;
   logic                     fe_cmd_v_d, fe_cmd_v_q;
   logic                     stall_d, stall_q;

   logic [vaddr_width_p-1:0] tgt;
   logic                     mispredict;
   logic                     branch_inc;

   // Same-cycle bypass: the resolving instruction and its successor may be
   // adjacent, so the incoming packet wins over the stored PC.
   assign tgt = br_v_i ? br_npc_i : npc_q;

   // Next-state, flush and counter-enable decode.
   always_comb begin
      state_d    = state_q;
      npc_d      = npc_q;
      npc_v_d    = npc_v_q;
      branch_d   = branch_q;
      taken_d    = taken_q;
      mispredict = 1'b0;
      branch_inc = 1'b0;
      case (state_q)
         e_run: begin
            if (br_v_i) begin
               npc_d      = br_npc_i;
               branch_d   = br_branch_i;
               taken_d    = br_btaken_i;
               npc_v_d    = 1'b1;
               branch_inc = br_branch_i;
            end
            if (issue_v_i && npc_v_q && (issue_pc_i != tgt)) begin
               mispredict = 1'b1;
               npc_d      = tgt;
               state_d    = e_redirect;
            end
         end
         e_redirect: begin
            // Packet and issue traffic is wrong-path here; only the FE matters.
            if (fe_cmd_ready_i) state_d = e_drain;
         end
         e_drain: begin
            // Wrong-path issues were already flushed; wait for the target PC.
            if (issue_v_i && (issue_pc_i == npc_q)) state_d = e_run;
         end
         default: state_d = e_run;
      endcase
      fe_cmd_v_d = (state_d == e_redirect);
      stall_d    = (state_d == e_redirect);
   end

   // FSM and command registers; reset drops the command immediately.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q    <= e_run;
         npc_q      <= reset_pc_p;
         npc_v_q    <= 1'b1;
         branch_q   <= 1'b0;
         taken_q    <= 1'b0;
         fe_cmd_v_q <= 1'b0;
         stall_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         npc_q      <= npc_d;
         npc_v_q    <= npc_v_d;
         branch_q   <= branch_d;
         taken_q    <= taken_d;
         fe_cmd_v_q <= fe_cmd_v_d;
         stall_q    <= stall_d;
      end
   end

   bp_be_perf_cnt #(.width_p(cnt_width_p)) u_branch_cnt (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .en_i      (branch_inc),
      .cnt_o     (branch_cnt_o)
   );

   bp_be_perf_cnt #(.width_p(cnt_width_p)) u_mispredict_cnt (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .en_i      (mispredict),
      .cnt_o     (mispredict_cnt_o)
   );

   assign flush_o         = mispredict;
   assign stall_o         = stall_q;
   assign fe_cmd_v_o      = fe_cmd_v_q;
   assign fe_cmd_npc_o    = npc_q;
   assign fe_cmd_branch_o = branch_q;
   assign fe_cmd_taken_o  = taken_q;
   assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_bp_be_npc_director.sv
// Directed bench for the next-PC director.
module tb_bp_be_npc_director;
   import bp_be_pkg::*;

   localparam int unsigned VW = 39;
   localparam int unsigned CW = 32;

   // ---------------- clock / reset ----------------
   logic clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   logic          reset_n_i;
   logic          br_v_i, br_branch_i, br_btaken_i;
   logic [VW-1:0] br_npc_i;
   logic          issue_v_i;
   logic [VW-1:0] issue_pc_i;
   logic          flush_o, stall_o;
   logic          fe_cmd_v_o, fe_cmd_ready_i;
   logic [VW-1:0] fe_cmd_npc_o;
   logic          fe_cmd_branch_o, fe_cmd_taken_o;
   logic [CW-1:0] branch_cnt_o, mispredict_cnt_o;
   bp_be_npc_dir_state_e dbg_state_o;

   bp_be_npc_director dut (
      .clk_i            (clk_i),
      .reset_n_i        (reset_n_i),
      .br_v_i           (br_v_i),
      .br_branch_i      (br_branch_i),
      .br_btaken_i      (br_btaken_i),
      .br_npc_i         (br_npc_i),
      .issue_v_i        (issue_v_i),
      .issue_pc_i       (issue_pc_i),
      .flush_o          (flush_o),
      .stall_o          (stall_o),
      .fe_cmd_v_o       (fe_cmd_v_o),
      .fe_cmd_ready_i   (fe_cmd_ready_i),
      .fe_cmd_npc_o     (fe_cmd_npc_o),
      .fe_cmd_branch_o  (fe_cmd_branch_o),
      .fe_cmd_taken_o   (fe_cmd_taken_o),
      .branch_cnt_o     (branch_cnt_o),
      .mispredict_cnt_o (mispredict_cnt_o),
      .dbg_state_o      (dbg_state_o)
   );

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic idle();
      br_v_i      = 1'b0;
      br_branch_i = 1'b0;
      br_btaken_i = 1'b0;
      br_npc_i    = '0;
      issue_v_i   = 1'b0;
      issue_pc_i  = '0;
   endtask

   // Advance one cycle; inputs are driven on the falling edge.
   task automatic tick();
      @(posedge clk_i);
      @(negedge clk_i);
   endtask

   task automatic drive_br(input logic br, input logic tk, input logic [VW-1:0] npc);
      br_v_i      = 1'b1;
      br_branch_i = br;
      br_btaken_i = tk;
      br_npc_i    = npc;
   endtask

   task automatic drive_issue(input logic [VW-1:0] pc);
      issue_v_i  = 1'b1;
      issue_pc_i = pc;
   endtask

   task automatic check_cmd(input string tag, input logic v, input logic [VW-1:0] npc,
                            input logic br, input logic tk);
      check({tag, "_v"},      64'(fe_cmd_v_o),      64'(v));
      check({tag, "_npc"},    64'(fe_cmd_npc_o),    64'(npc));
      check({tag, "_branch"}, 64'(fe_cmd_branch_o), 64'(br));
      check({tag, "_taken"},  64'(fe_cmd_taken_o),  64'(tk));
   endtask

   task automatic check_cnt(input string tag, input int br, input int mp);
      check({tag, "_brcnt"}, 64'(branch_cnt_o),     64'(br));
      check({tag, "_mpcnt"}, 64'(mispredict_cnt_o), 64'(mp));
   endtask

   // ---------------- stimulus ----------------
   logic [VW-1:0] hold_pcs [5];

   initial begin
      hold_pcs[0] = 39'h0080000100;
      hold_pcs[1] = 39'h0080000010;
      hold_pcs[2] = 39'h0080000008;
      hold_pcs[3] = 39'h0080000100;
      hold_pcs[4] = 39'h00800000F0;

      idle();
      fe_cmd_ready_i = 1'b0;
      reset_n_i      = 1'b0;
      #1;
      check("rst_flush", 64'(flush_o),    64'd0);
      check("rst_stall", 64'(stall_o),    64'd0);
      check("rst_cmdv",  64'(fe_cmd_v_o), 64'd0);
      check("rst_state", 64'(dbg_state_o), 64'(e_run));
      check_cnt("rst", 0, 0);
      @(negedge clk_i);
      @(negedge clk_i);
      reset_n_i = 1'b1;

      // Issue at the reset PC: match.
      drive_issue(39'h0080000000);
      #1 check("t1_flush", 64'(flush_o), 64'd0);
      tick(); idle();
      #1 check("t1_state", 64'(dbg_state_o), 64'(e_run));
      check_cnt("t1", 0, 0);

      // Non-branch packet, then matching issue next cycle.
      drive_br(1'b0, 1'b0, 39'h0080000004);
      #1 check("t2a_flush", 64'(flush_o), 64'd0);
      tick(); idle();
      drive_issue(39'h0080000004);
      #1 check("t2b_flush", 64'(flush_o), 64'd0);
      tick(); idle();
      #1 check_cnt("t2", 0, 0);

      // Taken branch with bypassed mismatching successor.
      drive_br(1'b1, 1'b1, 39'h0080000100);
      drive_issue(39'h0080000008);
      #1 check("t3_flush", 64'(flush_o), 64'd1);
      tick(); idle();
      #1 check_cmd("t3_cmd", 1'b1, 39'h0080000100, 1'b1, 1'b1);
      check("t3_stall", 64'(stall_o),     64'd1);
      check("t3_flush_off", 64'(flush_o), 64'd0);
      check("t3_state", 64'(dbg_state_o), 64'(e_redirect));
      check_cnt("t3", 1, 1);

      // Backpressure: traffic toggles, command must not move.
      for (int i = 0; i < 5; i++) begin
         idle();
         if (i[0]) drive_br(1'b1, 1'b0, 39'h0080000300 + VW'(i * 4));
         else      drive_issue(hold_pcs[i]);
         #1;
         check_cmd($sformatf("hold%0d", i), 1'b1, 39'h0080000100, 1'b1, 1'b1);
         check($sformatf("hold%0d_stall", i), 64'(stall_o), 64'd1);
         check($sformatf("hold%0d_flush", i), 64'(flush_o), 64'd0);
         check_cnt($sformatf("hold%0d", i), 1, 1);
         tick();
      end
      idle();
      fe_cmd_ready_i = 1'b1;
      #1 check("hs_cmdv", 64'(fe_cmd_v_o), 64'd1);
      tick();
      fe_cmd_ready_i = 1'b0;
      #1 check("drain_state", 64'(dbg_state_o), 64'(e_drain));
      check("drain_cmdv",  64'(fe_cmd_v_o), 64'd0);
      check("drain_stall", 64'(stall_o),    64'd0);

      // Drain: wrong-path issue and branch ignored, then the target resyncs.
      drive_issue(39'h0080000010);
      drive_br(1'b1, 1'b1, 39'h0080000500);
      #1 check("d1_flush", 64'(flush_o), 64'd0);
      tick(); idle();
      #1 check("d1_state", 64'(dbg_state_o), 64'(e_drain));
      check_cnt("d1", 1, 1);
      drive_issue(39'h0080000100);
      #1 check("d2_flush", 64'(flush_o), 64'd0);
      tick(); idle();
      #1 check("d2_state", 64'(dbg_state_o), 64'(e_run));

      // Back in RUN, the resynced PC is still expected.
      drive_issue(39'h0080000100);
      #1 check("r1_flush", 64'(flush_o), 64'd0);
      tick(); idle();

      // Mispredict without a packet: stored attributes are reused.
      drive_issue(39'h0080000200);
      #1 check("m2_flush", 64'(flush_o), 64'd1);
      tick(); idle();
      #1 check_cmd("m2_cmd", 1'b1, 39'h0080000100, 1'b1, 1'b1);
      check_cnt("m2", 1, 2);

      // Asynchronous reset in the middle of a redirect.
      #2 reset_n_i = 1'b0;
      #1 check("ar_cmdv", 64'(fe_cmd_v_o), 64'd0);
      check("ar_stall", 64'(stall_o),      64'd0);
      check("ar_state", 64'(dbg_state_o),  64'(e_run));
      check_cnt("ar", 0, 0);
      @(negedge clk_i);
      reset_n_i = 1'b1;

      // Ready asserted ahead of valid must not create a command.
      fe_cmd_ready_i = 1'b1;
      #1 check("rbv_cmdv", 64'(fe_cmd_v_o), 64'd0);
      tick();
      drive_issue(39'h0080000000);
      #1 check("pr_flush", 64'(flush_o), 64'd0);
      tick(); idle();
      drive_issue(39'h0080000004);
      #1 check("pr_mis_flush", 64'(flush_o), 64'd1);
      tick(); idle();
      #1 check_cmd("pr_cmd", 1'b1, 39'h0080000000, 1'b0, 1'b0);
      check_cnt("pr", 0, 1);
      tick();
      #1 check("pr_state", 64'(dbg_state_o), 64'(e_drain));
      check("pr_cmdv_off", 64'(fe_cmd_v_o), 64'd0);

      // ---------------- report ----------------
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
